// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared configuration for the pipelined adder slice:
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   chunk_width()                  : bits handled by one pipeline stage
//   params_ok()                    : legality check for a WIDTH/STAGES pair,
//                                    evaluated at elaboration by the top level
// Optional feature macro used by the top level: ADDER_OVERFLOW_DETECT_EN.
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;

   // Width of the carry-chain chunk owned by each stage.
   function automatic int chunk_width(input int width, input int stages);
      return (stages >= 1) ? (width / stages) : width;
   endfunction

   // A configuration is legal when there is at least one stage and the
   // operand splits into equal chunks.
   function automatic bit params_ok(input int width, input int stages);
      return (stages >= 1) && (width >= 1) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/add_slice.sv
// -----------------------------------------------------------------------------
// add_slice
// Combinational W-bit ripple-carry adder used as one chunk of the pipelined
// carry chain.
// Ports:
//   a_i, b_i [W-1:0] : operand chunks
//   cin_i            : carry into bit 0 of the chunk
//   sum_o  [W-1:0]   : chunk sum
//   cout_o           : carry out of the chunk MSB
// -----------------------------------------------------------------------------
module add_slice
   import adder_pkg::*;
#(
   parameter int W = chunk_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   logic [W-1:0] sum_d;
   logic         carry_d;

   // Explicit bit-serial ripple: the chunk is kept short so this chain is
   // the whole critical path of a stage.
   always_comb begin
      sum_d   = '0;
      carry_d = cin_i;
      for (int i = 0; i < W; i++) begin
         sum_d[i] = a_i[i] ^ b_i[i] ^ carry_d;
         carry_d  = (a_i[i] & b_i[i]) | (carry_d & (a_i[i] ^ b_i[i]));
      end
   end

   assign sum_o  = sum_d;
   assign cout_o = carry_d;

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// Pipelined ripple-carry adder: {carry_out, sum_out} = a_in + b_in + carry_in.
// The WIDTH-bit carry chain is cut into STAGES chunks of CHUNK bits; stage k
// adds chunk k using the carry registered by stage k-1. Valid/ready handshake
// on both sides, whole-pipeline stall under backpressure, 1 beat/cycle.
//
// Ports:
//   clk_in        : clock, rising edge
//   rst_in        : synchronous active-high reset
//   in_valid_in   : operand beat valid
//   in_ready_out  : beat can be accepted this cycle (= pipeline enable)
//   a_in, b_in    : operands [WIDTH-1:0]
//   carry_in      : carry into bit 0
//   out_valid_out : result valid
//   out_ready_in  : downstream accepts result
//   sum_out       : sum [WIDTH-1:0]
//   carry_out     : carry out of the MSB
//   ovf_out       : signed overflow flag
//
// Build option: define ADDER_OVERFLOW_DETECT_EN to register a two's-complement
// overflow flag with the final stage; otherwise ovf_out is constant 0.
// -----------------------------------------------------------------------------
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             in_valid_in,
   output logic             in_ready_out,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
   output logic             out_valid_out,
   input  logic             out_ready_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             ovf_out
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (!params_ok(WIDTH, STAGES)) begin : gen_param_check
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   // Stage k state. word_q[k] holds the finished sum chunks 0..k in its low
   // bits and the still-unused A chunks k+1.. in its high bits, so the A skew
   // and the sum deskew share one register per stage. bop_q[k] carries the
   // unused B chunks the same way; consumed B chunks are zeroed.
   logic [WIDTH-1:0]  word_q [STAGES];
   logic [WIDTH-1:0]  word_d [STAGES];
   logic [WIDTH-1:0]  bop_q  [STAGES];
   logic [WIDTH-1:0]  bop_d  [STAGES];
   logic [STAGES-1:0] carry_q;
   logic [STAGES-1:0] carry_d;
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic              en;

`ifdef ADDER_OVERFLOW_DETECT_EN
   logic ovf_q;
   logic ovf_d;
`endif

   // The pipeline moves as a whole: it only stalls when a result is waiting
   // and the consumer refuses it. No bubble collapsing.
   assign en           = !valid_q[STAGES-1] || out_ready_in;
   assign in_ready_out = en;

   genvar gi;
   for (gi = 0; gi < STAGES; gi++) begin : gen_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] a_next;
      logic [WIDTH-1:0] b_next;
      logic             cin_src;
      logic             valid_src;
      logic [CHUNK-1:0] slice_sum;
      logic             slice_cout;

      if (gi == 0) begin : gen_head
         assign a_src     = a_in;
         assign b_src     = b_in;
         assign cin_src   = carry_in;
         assign valid_src = in_valid_in;
      end else begin : gen_body
         assign a_src     = word_q[gi-1];
         assign b_src     = bop_q[gi-1];
         assign cin_src   = carry_q[gi-1];
         assign valid_src = valid_q[gi-1];
      end

      add_slice #(
         .W (CHUNK)
      ) u_slice (
         .a_i    (a_src[gi*CHUNK +: CHUNK]),
         .b_i    (b_src[gi*CHUNK +: CHUNK]),
         .cin_i  (cin_src),
         .sum_o  (slice_sum),
         .cout_o (slice_cout)
      );

      // Chunk gi of A is replaced in place by its sum chunk.
      always_comb begin
         a_next = a_src;
         a_next[gi*CHUNK +: CHUNK] = slice_sum;
         b_next = b_src;
         b_next[gi*CHUNK +: CHUNK] = '0;
      end

      assign word_d[gi]  = a_next;
      assign bop_d[gi]   = b_next;
      assign carry_d[gi] = slice_cout;
      assign valid_d[gi] = valid_src;

`ifdef ADDER_OVERFLOW_DETECT_EN
      // At the last stage the top chunks of a_src/b_src are still the
      // original operand chunks, so their MSBs are the operand sign bits.
      if (gi == STAGES - 1) begin : gen_ovf
         assign ovf_d = (a_src[WIDTH-1] == b_src[WIDTH-1]) &&
                        (slice_sum[CHUNK-1] != a_src[WIDTH-1]);
      end
`endif
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int k = 0; k < STAGES; k++) begin
            word_q[k] <= '0;
            bop_q[k]  <= '0;
         end
         carry_q <= '0;
         valid_q <= '0;
      end else if (en) begin
         // Data moves even for bubbles; only valid_q is authoritative.
         for (int k = 0; k < STAGES; k++) begin
            word_q[k] <= word_d[k];
            bop_q[k]  <= bop_d[k];
         end
         carry_q <= carry_d;
         valid_q <= valid_d;
      end
   end

`ifdef ADDER_OVERFLOW_DETECT_EN
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf_out = ovf_q;
`else
   assign ovf_out = 1'b0;
`endif

   assign out_valid_out = valid_q[STAGES-1];
   assign sum_out       = word_q[STAGES-1];
   assign carry_out     = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

   localparam int W = 32;
   localparam int S = 4;

`ifdef ADDER_OVERFLOW_DETECT_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst       = 1'b1;
   // main 32-bit / 4-stage instance
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a         = '0;
   logic [W-1:0]  b         = '0;
   logic          cin       = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   // small 3-bit / 3-stage instance for the exhaustive sweep
   logic          v3        = 1'b0;
   logic          r3_in;
   logic [2:0]    a3        = '0;
   logic [2:0]    b3        = '0;
   logic          c3        = 1'b0;
   logic          ov3;
   logic          or3       = 1'b1;
   logic [2:0]    s3;
   logic          co3;
   logic          of3;
   bit            rand_ready3 = 1'b0;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .in_valid_in   (in_valid),
      .in_ready_out  (in_ready),
      .a_in          (a),
      .b_in          (b),
      .carry_in      (cin),
      .out_valid_out (out_valid),
      .out_ready_in  (out_ready),
      .sum_out       (sum),
      .carry_out     (cout),
      .ovf_out       (ovf)
   );

   pipelined_adder #(.WIDTH(3), .STAGES(3)) u_dut3 (
      .clk_in        (clk),
      .rst_in        (rst),
      .in_valid_in   (v3),
      .in_ready_out  (r3_in),
      .a_in          (a3),
      .b_in          (b3),
      .carry_in      (c3),
      .out_valid_out (ov3),
      .out_ready_in  (or3),
      .sum_out       (s3),
      .carry_out     (co3),
      .ovf_out       (of3)
   );

   // Directed vectors with hand-computed results.
   logic [31:0] tbl_a   [12] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                                 32'h00000000, 32'h12345678, 32'h80000000, 32'h0000FFFF,
                                 32'h00FFFFFF, 32'hDEADBEEF, 32'h7FFFFFFF, 32'hAAAAAAAA};
   logic [31:0] tbl_b   [12] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                                 32'h00000000, 32'h87654321, 32'h80000000, 32'h00000001,
                                 32'h00000000, 32'h01234567, 32'h7FFFFFFF, 32'h55555555};
   logic        tbl_ci  [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [31:0] tbl_sum [12] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,
                                 32'h00000001, 32'h99999999, 32'h00000000, 32'h00010000,
                                 32'h01000000, 32'hDFD10457, 32'hFFFFFFFF, 32'h00000000};
   logic        tbl_co  [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        tbl_ov  [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   typedef struct packed {
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
   } exp_t;

   exp_t       cur_exp;
   exp_t       q_main [$];
   logic [4:0] q3 [$];        // {carry, sum[2:0], ovf}
   int pass_cnt  = 0;
   int total_cnt = 0;
   int got_main  = 0;
   int match3    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      total_cnt++;
      if (act === exp_v) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
   endtask

   // Scoreboard: pushes on input handshake, pops/compares on output handshake.
   always @(negedge clk) begin
      if (rst) begin
         q_main.delete();
         q3.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("main_result_expected", q_main.size() != 0, 1);
            if (q_main.size() != 0) begin
               exp_t e;
               e = q_main.pop_front();
               $display("main result #%0d: sum=0x%08h carry=%0d ovf=%0d (exp 0x%08h %0d %0d)",
                        got_main, sum, cout, ovf, e.sum, e.carry, e.ovf);
               check("main_sum", sum, e.sum);
               check("main_carry", cout, e.carry);
               check("main_ovf", ovf, e.ovf);
               got_main++;
            end
         end
         if (in_valid && in_ready) q_main.push_back(cur_exp);

         if (ov3 && or3) begin
            check("x3_result_expected", q3.size() != 0, 1);
            if (q3.size() != 0) begin
               logic [4:0] e3;
               e3 = q3.pop_front();
               $display("x3 result: {carry,sum,ovf}=0x%02h exp 0x%02h", {co3, s3, of3}, e3);
               check("x3_result", {co3, s3, of3}, e3);
               if ({co3, s3, of3} == e3) match3++;
            end
         end
         if (v3 && r3_in) begin
            logic [3:0] full;
            logic       o;
            full = {1'b0, a3} + {1'b0, b3} + {3'b000, c3};
            o    = OVF_ON && (a3[2] == b3[2]) && (full[2] != a3[2]);
            q3.push_back({full[3], full[2:0], o});
         end
      end
   end

   always @(posedge clk) begin
      #1;
      or3 = rand_ready3 ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_vec(input int i);
      in_valid = 1'b1;
      a        = tbl_a[i];
      b        = tbl_b[i];
      cin      = tbl_ci[i];
      cur_exp  = {tbl_sum[i], tbl_co[i], OVF_ON & tbl_ov[i]};
   endtask

   // Present a vector and hold it until accepted (bounded).
   task automatic send(input int i);
      bit done;
      done = 1'b0;
      drive_vec(i);
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         tick();
      end
      if (!done) check("send_accept_timeout", done, 1);
      in_valid = 1'b0;
   endtask

   task automatic send3(input int av, input int bv, input int cv);
      bit done;
      done = 1'b0;
      v3 = 1'b1;
      a3 = 3'(av);
      b3 = 3'(bv);
      c3 = 1'(cv);
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (r3_in) done = 1'b1;
         tick();
      end
      if (!done) check("send3_accept_timeout", done, 1);
      v3 = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;
      int cnt;
      int base;
      logic [31:0] held_sum;
      logic        held_c;

      // ---------------- reset state ----------------
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_sum", sum, 0);
      check("reset_carry", cout, 0);
      check("reset_ovf", ovf, 0);
      check("reset_in_ready", in_ready, 1);
      tick();

      // ---------------- 1: latency of a single beat ----------------
      drive_vec(0);
      tick();
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 20) begin
         tick();
         edges++;
      end
      check("latency_edges", edges, S);
      repeat (4) tick();

      // ---------------- 2: 8 back-to-back beats ----------------
      base = got_main;
      fork
         begin
            for (int i = 1; i <= 8; i++) send(i);
         end
         begin
            cnt = 0;
            for (int t = 0; t < 30 && !out_valid; t++) @(negedge clk);
            repeat (8) begin
               if (out_valid) cnt++;
               @(negedge clk);
            end
            check("b2b_consecutive_valid", cnt, 8);
         end
      join
      repeat (8) tick();
      check("b2b_delivered", got_main - base, 8);

      // ---------------- 3: backpressure ----------------
      base = got_main;
      fork
         begin
            for (int i = 0; i < 12; i++) send(i);
         end
         begin
            for (int t = 0; t < 30 && !out_valid; t++) @(negedge clk);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            held_sum = sum;
            held_c   = cout;
            check("bp_in_ready_0", in_ready, 0);
            check("bp_valid_held", out_valid, 1);
            for (int k = 1; k < 3; k++) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 0);
               check("bp_sum_stable", sum, held_sum);
               check("bp_carry_stable", cout, held_c);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      for (int t = 0; t < 40 && q_main.size() != 0; t++) tick();
      repeat (2) tick();
      check("bp_delivered", got_main - base, 12);

      // ---------------- 4: reset mid-flight ----------------
      drive_vec(0);
      tick();
      drive_vec(1);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", sum, 0);
      check("midrst_carry", cout, 0);
      check("midrst_in_ready", in_ready, 1);
      rst = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("midrst_no_stale", cnt, 0);
      tick();

      // ---------------- 5: overflow vector (0x7FFFFFFF + 1) ----------------
      base = got_main;
      send(1);
      for (int t = 0; t < 20 && q_main.size() != 0; t++) tick();
      check("ovf_vector_delivered", got_main - base, 1);

      // ---------------- 6: exhaustive 3-bit sweep ----------------
      rand_ready3 = 1'b1;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            for (int k = 0; k < 2; k++)
               send3(i, j, k);
      rand_ready3 = 1'b0;
      for (int t = 0; t < 100 && q3.size() != 0; t++) tick();
      repeat (2) tick();
      check("x3_exhaustive_matches", match3, 128);
      check("main_queue_drained", q_main.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder. It is the sequential successor of the single-bit full adder. Computes {carry_out, sum_out} = a_in + b_in + carry_in over WIDTH bits. The carry chain is split into STAGES registered chunks, so the critical path is one chunk. Valid/ready handshake on input and output with full backpressure, one result per cycle sustained. Used wherever datapath adds must close timing at high clock rates.

Parameters:
WIDTH, 32, operand/sum width in bits; must be divisible by STAGES.
STAGES, 4, pipeline depth and carry-chain chunk count; >= 1. CHUNK = WIDTH/STAGES is a derived localparam.

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous active-high reset
in_valid_in  input  1  operand beat valid
in_ready_out  output  1  block can accept a beat this cycle
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
carry_in  input  1  carry into bit 0
out_valid_out  output  1  result valid
out_ready_in  input  1  downstream accepts result
sum_out  output  WIDTH  sum
carry_out  output  1  carry out of MSB
ovf_out  output  1  signed overflow flag; see Optional Feature

Behaviour:
- Reset (rst_in=1 at posedge):
  - All stage valid bits, data, carry and skew registers clear to 0.
  - Outputs after reset: out_valid_out=0, sum_out=0, carry_out=0, ovf_out=0, in_ready_out=1.
  - Reset mid-operation discards all in-flight beats; none emerges afterwards.
- Pipeline enable: en = !out_valid_out | out_ready_in. The whole pipeline advances only when en=1. There is no bubble collapsing.
- in_ready_out = en, combinational from out_valid_out and out_ready_in only, never from in_valid_in.
- Accept: a beat is taken at a posedge where in_valid_in & in_ready_out. If in_valid_in=0 while en=1, a bubble (valid=0) enters stage 0.
- Stage k (0..STAGES-1) on en:
  - Adds chunk k of A and B plus the carry registered from stage k-1 (stage 0 uses carry_in).
  - Registers the CHUNK-bit partial sum and the chunk carry.
- Skew and deskew:
  - Upper operand chunks are delayed through skew registers so chunk k arrives at stage k.
  - Lower sum chunks are delayed through deskew registers so all chunks leave together.
- Latency: exactly STAGES cycles from accept to out_valid_out=1 when out_ready_in is held 1. STAGES=1 gives a single registered adder.
- Throughput: 1 beat/cycle with out_ready_in=1. Results are in order, with no loss and no duplication.
- Backpressure:
  - While out_valid_out=1 & out_ready_in=0, all registers hold and outputs stay stable.
  - in_ready_out=0 during that time.
  - in_valid_in, a_in and b_in are ignored.
- Simultaneous accept and output handshake in one cycle is legal: both complete and the pipeline shifts.
- Arithmetic: unsigned modulo 2^WIDTH. carry_out is bit WIDTH of the full sum. Extreme case: all-ones + all-ones + 1 gives sum=all-ones, carry=1.
- Data registers update on en even for bubbles; only valid bits are authoritative.

Optional Feature:
Macro ADDER_OVERFLOW_DETECT_EN.
- Defined: ovf_out is registered alongside the final stage and equals the two's-complement signed overflow, (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]). Operand MSBs are carried through the skew path.
- Undefined: ovf_out is tied to constant 0 and no extra registers are built.
- The port is present in both cases.

Decomposition:
- Package adder_pkg holds:
  - the default WIDTH/STAGES localparams,
  - a function computing CHUNK,
  - an elaboration-time check function that errors if WIDTH % STAGES != 0 or STAGES < 1.
- One sub-module, add_slice: a parametrised CHUNK-bit combinational ripple adder (a, b, cin -> sum, cout), instantiated STAGES times by generate.
- The top level owns all registers, skew/deskew and the handshake.

Test Plan:
1. WIDTH=32, STAGES=4, out_ready_in=1: a=0xFFFFFFFF, b=0x00000001, cin=0 accepted at cycle 0 -> cycle 4: out_valid_out=1, sum=0x00000000, carry_out=1.
2. 8 back-to-back random beats, out_ready_in=1 -> 8 consecutive valid results from cycle 4 to 11, in order, each equal to a+b+cin.
3. Backpressure: stream beats and drop out_ready_in for 3 cycles while out_valid_out=1 -> in_ready_out=0 for those 3 cycles, sum_out/carry_out stable, every beat delivered exactly once after release.
4. Reset mid-flight: accept 2 beats, assert rst_in at cycle 2 -> at cycle 3 out_valid_out=0, sum_out=0, in_ready_out=1, and no stale result ever appears.
5. With ADDER_OVERFLOW_DETECT_EN: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf_out=1, carry_out=0. Without the macro the same stimulus gives ovf_out=0.
6. WIDTH=3, STAGES=3, exhaustive 128 combinations of a, b, cin with random out_ready_in -> every result matches the scoreboard value a+b+cin; bench prints PASSED only if the score equals 128.
